// File: rtl/freq_div_ctrl_pkg.sv
// Shared types and sizing helpers for the frequency-divider configuration arbiter.
package freq_div_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STOP,
    LOAD,
    SETTLE,
    START
  } stateT;

  localparam int unsigned DIV_W_DEF         = 32;
  localparam int unsigned MIN_DIV           = 2;
  localparam int unsigned STOP_CYCLES_DEF   = 1;
  localparam int unsigned SETTLE_CYCLES_DEF = 2;

  // The counter is preloaded with (cycles - 1), so it only has to hold max-1.
  function automatic int unsigned seqCntW(input int unsigned stopCycles,
                                          input int unsigned settleCycles);
    int unsigned m;
    m = (stopCycles > settleCycles) ? stopCycles : settleCycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int unsigned SEQ_CNT_W = seqCntW(STOP_CYCLES_DEF, SETTLE_CYCLES_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  int unsigned idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/freq_div_cfg_arbiter.sv
// Arbitrates divisor requests and sequences a shared FrequencyDivider: stop, load, settle, start.
module freq_div_cfg_arbiter
  import freq_div_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned DIV_W         = DIV_W_DEF,
  parameter int unsigned STOP_CYCLES   = STOP_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     run_en,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DIV_W-1:0]   req_div,
  output logic [N_REQ-1:0]         ack,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] cur_owner,
  output logic [DIV_W-1:0]         cur_div,
  output logic [DIV_W-1:0]         div_Din,
  output logic                     div_ConfigDiv,
  output logic                     div_Enable
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = seqCntW(STOP_CYCLES, SETTLE_CYCLES);

  stateT             state, stateD;
  logic [CNT_W-1:0]  cnt, cntD;
  logic [IDX_W-1:0]  rrPtr, rrPtrD;
  logic              configured, configuredD;
  logic [DIV_W-1:0]  latchDiv, latchDivD;
  logic [IDX_W-1:0]  latchIdx, latchIdxD;

  logic [N_REQ-1:0]  ackD;
  logic              errD, busyD, cfgD, enD;
  logic [IDX_W-1:0]  curOwnerD;
  logic [DIV_W-1:0]  curDivD, dinD;

  logic              grantValid;
  logic [IDX_W-1:0]  grantIdx;
  logic [DIV_W-1:0]  grantDiv;
  int unsigned       ptrNext;

  rr_arbiter #(.N_REQ(N_REQ)) uArb (
    .req         (req),
    .rr_ptr      (rrPtr),
    .grant_valid (grantValid),
    .grant_idx   (grantIdx)
  );

  assign grantDiv = req_div[grantIdx*DIV_W +: DIV_W];

  // Outputs are registered from the next state, so each value appears during the cycle of
  // the state it belongs to. Sampling is held off while an ack is out so the acked requester
  // can drop req before it could be granted twice.
  always_comb begin
    stateD      = state;
    cntD        = cnt;
    rrPtrD      = rrPtr;
    configuredD = configured;
    latchDivD   = latchDiv;
    latchIdxD   = latchIdx;
    ackD        = '0;
    errD        = 1'b0;
    curOwnerD   = cur_owner;
    curDivD     = cur_div;
    dinD        = div_Din;
    cfgD        = 1'b0;
    enD         = 1'b0;
    ptrNext     = int'(grantIdx) + 1;
    if (ptrNext >= N_REQ) ptrNext = 0;

    case (state)
      IDLE: begin
        enD = run_en & configured;
        if (grantValid && (ack == '0)) begin
          rrPtrD = IDX_W'(ptrNext);
          if (grantDiv < DIV_W'(MIN_DIV)) begin
            ackD[grantIdx] = 1'b1;
            errD           = 1'b1;
          end else if (configured && (grantDiv == cur_div)) begin
            ackD[grantIdx] = 1'b1;
            curOwnerD      = grantIdx;
          end else begin
            latchDivD = grantDiv;
            latchIdxD = grantIdx;
            stateD    = STOP;
            cntD      = CNT_W'(STOP_CYCLES - 1);
            enD       = 1'b0;
          end
        end
      end
      STOP: begin
        if (cnt == '0) begin
          stateD = LOAD;
          cfgD   = 1'b1;
          dinD   = latchDiv;
        end else begin
          cntD = cnt - 1'b1;
        end
      end
      LOAD: begin
        stateD = SETTLE;
        cntD   = CNT_W'(SETTLE_CYCLES - 1);
      end
      SETTLE: begin
        if (cnt == '0) begin
          stateD         = START;
          ackD[latchIdx] = 1'b1;
          enD            = run_en;
        end else begin
          cntD = cnt - 1'b1;
        end
      end
      START: begin
        stateD      = IDLE;
        curDivD     = latchDiv;
        curOwnerD   = latchIdx;
        configuredD = 1'b1;
        enD         = run_en;
      end
      default: stateD = IDLE;
    endcase

    busyD = (stateD != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      rrPtr         <= '0;
      configured    <= 1'b0;
      latchDiv      <= '0;
      latchIdx      <= '0;
      ack           <= '0;
      err           <= 1'b0;
      busy          <= 1'b0;
      cur_owner     <= '0;
      cur_div       <= '0;
      div_Din       <= '0;
      div_ConfigDiv <= 1'b0;
      div_Enable    <= 1'b0;
    end else begin
      state         <= stateD;
      cnt           <= cntD;
      rrPtr         <= rrPtrD;
      configured    <= configuredD;
      latchDiv      <= latchDivD;
      latchIdx      <= latchIdxD;
      ack           <= ackD;
      err           <= errD;
      busy          <= busyD;
      cur_owner     <= curOwnerD;
      cur_div       <= curDivD;
      div_Din       <= dinD;
      div_ConfigDiv <= cfgD;
      div_Enable    <= enD;
    end
  end

endmodule

// File: tb/tb_freq_div_cfg_arbiter.sv
// Self-checking bench for freq_div_cfg_arbiter: latency sequence, arbitration order, vector table, reset abort.
module tb_freq_div_cfg_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           runEn;
  logic [N-1:0]   req;
  logic [N*W-1:0] reqDiv;
  logic [N-1:0]   ack;
  logic           err;
  logic           busy;
  logic [1:0]     curOwner;
  logic [W-1:0]   curDiv;
  logic [W-1:0]   divDin;
  logic           divConfigDiv;
  logic           divEnable;

  freq_div_cfg_arbiter #(
    .N_REQ(N), .DIV_W(W), .STOP_CYCLES(1), .SETTLE_CYCLES(2)
  ) dut (
    .Clk(clk), .Reset(reset), .run_en(runEn), .req(req), .req_div(reqDiv),
    .ack(ack), .err(err), .busy(busy), .cur_owner(curOwner), .cur_div(curDiv),
    .div_Din(divDin), .div_ConfigDiv(divConfigDiv), .div_Enable(divEnable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] ack;
    logic         err;
    int           pulses;
  } expT;

  typedef struct {
    int           idx;
    logic [W-1:0] div;
    logic         err;
    int           pulses;
    logic [W-1:0] curDiv;
    int           owner;
  } vecT;

  expT sbQ[$];
  int  tests = 0;
  int  fails = 0;
  int  cfgPulses = 0;
  logic prevCfg = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Scoreboard side: every ack pops the oldest expectation.
  always @(negedge clk) begin
    if (divConfigDiv === 1'b1) cfgPulses++;
    if (prevCfg === 1'b1 && divConfigDiv === 1'b1) chk("cfgPulseWidth", 1, 0);
    prevCfg = divConfigDiv;
    if (err === 1'b1 && ack === '0) chk("errWithoutAck", 1, 0);
    if (ack !== '0 && !$isunknown(ack)) begin
      if (sbQ.size() == 0) begin
        chk("unexpectedAck", 64'(ack), 0);
      end else begin
        expT e;
        e = sbQ.pop_front();
        chk("sbAck", 64'(ack), 64'(e.ack));
        chk("sbErr", 64'(err), 64'(e.err));
        chk("sbCfgPulses", 64'(cfgPulses), 64'(e.pulses));
      end
      cfgPulses = 0;
    end
  end

  task automatic waitAck(input int idx, output bit enDropped);
    bit ok = 0;
    enDropped = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (divEnable !== 1'b1) enDropped = 1;
      if (ack[idx] === 1'b1) begin
        ok = 1;
        break;
      end
    end
    chk("ackTimeout", 64'(ok), 1);
  endtask

  task automatic runReq(input int idx, input logic [W-1:0] div, input logic expErr,
                        input int expPulses, output bit enDropped);
    expT e;
    e.ack = '0;
    e.ack[idx] = 1'b1;
    e.err = expErr;
    e.pulses = expPulses;
    sbQ.push_back(e);
    reqDiv[idx*W +: W] = div;
    req[idx] = 1'b1;
    waitAck(idx, enDropped);
    req[idx] = 1'b0;
    @(negedge clk);
  endtask

  vecT vecs[6];
  bit  drop;

  initial begin
    vecs[0] = '{idx: 1, div: 1, err: 1, pulses: 0, curDiv: 4, owner: 0};
    vecs[1] = '{idx: 1, div: 0, err: 1, pulses: 0, curDiv: 4, owner: 0};
    vecs[2] = '{idx: 3, div: 4, err: 0, pulses: 0, curDiv: 4, owner: 3};
    vecs[3] = '{idx: 2, div: 9, err: 0, pulses: 1, curDiv: 9, owner: 2};
    vecs[4] = '{idx: 2, div: 9, err: 0, pulses: 0, curDiv: 9, owner: 2};
    vecs[5] = '{idx: 0, div: 2, err: 0, pulses: 1, curDiv: 2, owner: 0};

    reset = 1'b1;
    runEn = 1'b1;
    req = '0;
    reqDiv = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rstOutputs", {ack, err, busy, curOwner, divConfigDiv, divEnable}, '0);
    chk("rstCurDiv", 64'(curDiv), 0);
    chk("rstDin", 64'(divDin), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("unconfiguredEnable", {busy, divEnable}, 0);

    // Cycle-exact first configuration: requester 0, divisor 5
    begin
      expT e;
      e.ack = 4'b0001; e.err = 1'b0; e.pulses = 1;
      sbQ.push_back(e);
    end
    reqDiv[0 +: W] = 5;
    req[0] = 1'b1;
    @(negedge clk);
    chk("t1Stop", {busy, divConfigDiv, divEnable}, 3'b100);
    @(negedge clk);
    chk("t2Load", {busy, divConfigDiv, divEnable}, 3'b110);
    chk("t2Din", 64'(divDin), 5);
    @(negedge clk);
    chk("t3Settle", {busy, divConfigDiv, divEnable, ack}, 7'b1000000);
    @(negedge clk);
    chk("t4Settle", {busy, divConfigDiv, divEnable, ack}, 7'b1000000);
    @(negedge clk);
    chk("t5Start", {busy, divEnable, ack}, 6'b110001);
    req[0] = 1'b0;
    @(negedge clk);
    chk("t6Idle", {busy, divEnable, ack}, 6'b010000);
    chk("t6CurDiv", 64'(curDiv), 5);
    chk("t6Owner", 64'(curOwner), 0);
    chk("t6DinHeld", 64'(divDin), 5);

    // Round-robin: pointer is at 1, so requester 2 beats requester 0
    begin
      expT e;
      e.ack = 4'b0100; e.err = 1'b0; e.pulses = 1;
      sbQ.push_back(e);
      e.ack = 4'b0001;
      sbQ.push_back(e);
    end
    reqDiv[0 +: W] = 4;
    reqDiv[2*W +: W] = 8;
    req[0] = 1'b1;
    req[2] = 1'b1;
    waitAck(2, drop);
    req[2] = 1'b0;
    @(negedge clk);
    chk("rrFirstDiv", 64'(curDiv), 8);
    chk("rrFirstOwner", 64'(curOwner), 2);
    waitAck(0, drop);
    req[0] = 1'b0;
    @(negedge clk);
    chk("rrSecondDiv", 64'(curDiv), 4);
    chk("rrSecondOwner", 64'(curOwner), 0);

    // Rejects, skips and the minimum accepted divisor
    for (int i = 0; i < 6; i++) begin
      runReq(vecs[i].idx, vecs[i].div, vecs[i].err, vecs[i].pulses, drop);
      chk($sformatf("vec%0dCurDiv", i), 64'(curDiv), 64'(vecs[i].curDiv));
      chk($sformatf("vec%0dOwner", i), 64'(curOwner), 64'(vecs[i].owner));
      if (vecs[i].pulses == 0) chk($sformatf("vec%0dEnableHeld", i), 64'(drop), 0);
      chk($sformatf("vec%0dIdle", i), {busy, divEnable}, 2'b01);
    end

    // Reset during SETTLE aborts the sequence without an ack
    reqDiv[1*W +: W] = 7;
    req[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abortInSettle", {busy, divConfigDiv, divEnable}, 3'b100);
    reset = 1'b1;
    @(negedge clk);
    chk("abortOutputs", {ack, err, busy, curOwner, divConfigDiv, divEnable}, '0);
    chk("abortCurDiv", 64'(curDiv), 0);
    chk("abortDin", 64'(divDin), 0);
    reset = 1'b0;
    req[1] = 1'b0;
    cfgPulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("abortEnable%0d", c), {busy, divEnable}, 0);
    end
    runReq(0, 6, 1'b0, 1, drop);
    chk("reconfigDiv", 64'(curDiv), 6);
    chk("reconfigOwner", 64'(curOwner), 0);
    chk("reconfigEnable", 64'(divEnable), 1);

    @(negedge clk);
    chk("sbDrained", 64'(sbQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
